pulse_analyzer: RTL and testbench

Measures an incoming single-bit pulse train and reports, for every complete pulse, its high time (width) and its rising-to-rising distance (period) in clock cycles. It is the receive-side counterpart of `pulse_generator` and is used in loopback to check generated pulse trains. It also measures external trigger and sync signals. Results are presented as a one-cycle `valid` strobe with registered values, suitable for a status register or a FIFO.

---
 rtl/pulse_analyzer_pkg.sv | 12 +
 rtl/edge_detector.sv | 31 +++
 rtl/pulse_analyzer.sv | 166 ++++++++++++++++
 tb/tb_pulse_analyzer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_analyzer_pkg.sv
// Shared FSM encodings and synchronizer depth for the pulse analyzer.
package pulse_analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/edge_detector.sv
// Synchronizes the asynchronous pulse input and flags its rising/falling edges.
// Latency: edges flagged combinationally in the cycle after the last sync stage; no backpressure.
module edge_detector
    import pulse_analyzer_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

endmodule

// File: rtl/pulse_analyzer.sv
// Measures high time and rise-to-rise period of each complete pulse on din.
// Latency: result strobed two edges after the closing rise is first sampled; no backpressure, outputs are strobes.
module pulse_analyzer
    import pulse_analyzer_pkg::*;
#(
    parameter int PULSE_WIDTH_WIDTH  = 8,
    parameter int PULSE_PERIOD_WIDTH = 16,
    parameter int COUNT_WIDTH        = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          en,
    input  logic                          din,
    output logic [PULSE_WIDTH_WIDTH-1:0]  width,
    output logic [PULSE_PERIOD_WIDTH-1:0] period,
    output logic                          valid,
    output logic                          width_sat,
    output logic                          timeout,
    output logic [COUNT_WIDTH-1:0]        pulse_count
);

    logic s_unused;
    logic rise;
    logic fall;

    edge_detector u_edge (
        .clk    (clk),
        .resetn (resetn),
        .din    (din),
        .s      (s_unused),
        .rise   (rise),
        .fall   (fall)
    );

    state_t state_q, state_d;

    logic [PULSE_WIDTH_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic [PULSE_WIDTH_WIDTH-1:0]  wlat_q, wlat_d;
    logic [PULSE_PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                          sat_q, sat_d;

    logic [PULSE_WIDTH_WIDTH-1:0]  width_q, width_d;
    logic [PULSE_PERIOD_WIDTH-1:0] period_q, period_d;
    logic                          valid_q, valid_d;
    logic                          width_sat_q, width_sat_d;
    logic                          timeout_q, timeout_d;
    logic [COUNT_WIDTH-1:0]        count_q, count_d;

    logic pcnt_max;
    logic meas_done;
    logic timeout_hit;
    logic restart;

    assign pcnt_max = &pcnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // en has priority over every transition, including a completing rise.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (rise) state_d = ST_HIGH;
                ST_HIGH: begin
                    if (pcnt_max)  state_d = ST_IDLE;
                    else if (fall) state_d = ST_LOW;
                end
                ST_LOW: begin
                    if (rise)          state_d = ST_HIGH;
                    else if (pcnt_max) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        meas_done   = en && (state_q == ST_LOW) && rise;
        timeout_hit = en && (state_q != ST_IDLE) && pcnt_max && !meas_done;
        restart     = en && rise && ((state_q == ST_IDLE) || (state_q == ST_LOW));
    end

    always_comb begin
        wcnt_d = wcnt_q;
        pcnt_d = pcnt_q;
        wlat_d = wlat_q;
        sat_d  = sat_q;
        if (restart) begin
            wcnt_d = PULSE_WIDTH_WIDTH'(1);
            pcnt_d = PULSE_PERIOD_WIDTH'(1);
            sat_d  = 1'b0;
        end else if (state_d == ST_IDLE) begin
            wcnt_d = '0;
            pcnt_d = '0;
            sat_d  = 1'b0;
        end else begin
            pcnt_d = pcnt_q + PULSE_PERIOD_WIDTH'(1);
            if (state_q == ST_HIGH) begin
                if (fall) begin
                    wlat_d = wcnt_q;
                end else if (&wcnt_q) begin
                    sat_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + PULSE_WIDTH_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        width_d     = width_q;
        period_d    = period_q;
        width_sat_d = width_sat_q;
        count_d     = count_q;
        valid_d     = meas_done;
        timeout_d   = timeout_hit;
        if (meas_done) begin
            width_d     = wlat_q;
            period_d    = pcnt_q;
            width_sat_d = sat_q;
            count_d     = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wcnt_q      <= '0;
            pcnt_q      <= '0;
            wlat_q      <= '0;
            sat_q       <= 1'b0;
            width_q     <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            width_sat_q <= 1'b0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            pcnt_q      <= pcnt_d;
            wlat_q      <= wlat_d;
            sat_q       <= sat_d;
            width_q     <= width_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            width_sat_q <= width_sat_d;
            timeout_q   <= timeout_d;
            count_q     <= count_d;
        end
    end

    assign width       = width_q;
    assign period      = period_q;
    assign valid       = valid_q;
    assign width_sat   = width_sat_q;
    assign timeout     = timeout_q;
    assign pulse_count = count_q;

endmodule

// File: tb/tb_pulse_analyzer.sv
// Directed bench for pulse_analyzer: drives pulse trains on din and checks recorded results.
module tb_pulse_analyzer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic        din;
    logic [7:0]  width;
    logic [15:0] period;
    logic        valid;
    logic        width_sat;
    logic        timeout;
    logic [31:0] pulse_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int r0       = 0;

    logic [7:0]  q_w[$];
    logic [15:0] q_p[$];
    logic        q_s[$];
    int          q_c[$];
    int          to_cnt     = 0;
    int          to_cyc     = 0;
    int          strobe_err = 0;
    logic        prev_v     = 1'b0;
    logic        prev_t     = 1'b0;

    pulse_analyzer dut (
        .clk         (clk),
        .resetn      (resetn),
        .en          (en),
        .din         (din),
        .width       (width),
        .period      (period),
        .valid       (valid),
        .width_sat   (width_sat),
        .timeout     (timeout),
        .pulse_count (pulse_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            q_w.push_back(width);
            q_p.push_back(period);
            q_s.push_back(width_sat);
            q_c.push_back(cyc);
        end
        if (timeout === 1'b1) begin
            to_cnt = to_cnt + 1;
            to_cyc = cyc;
        end
        if ((valid === 1'b1 && timeout === 1'b1) ||
            (valid === 1'b1 && prev_v === 1'b1) ||
            (timeout === 1'b1 && prev_t === 1'b1))
            strobe_err = strobe_err + 1;
        prev_v = valid;
        prev_t = timeout;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_entry(input string tag, input int i, input int w, input int p, input logic s);
        if (i >= q_w.size()) begin
            checks++;
            failures++;
            $error("FAIL %s entry%0d observed=absent expected=present", tag, i);
        end else begin
            chk({tag, "_width"}, 64'(q_w[i]), 64'(w));
            chk({tag, "_period"}, 64'(q_p[i]), 64'(p));
            chk({tag, "_sat"}, 64'(q_s[i]), 64'(s));
        end
    endtask

    function automatic int cyc_at(input int i);
        return (i < q_c.size()) ? q_c[i] : -1;
    endfunction

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int per);
        hold(1'b1, hi);
        hold(1'b0, per - hi);
    endtask

    task automatic clr();
        q_w.delete();
        q_p.delete();
        q_s.delete();
        q_c.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_width"}, 64'(width), 64'd0);
        chk({tag, "_period"}, 64'(period), 64'd0);
        chk({tag, "_valid"}, 64'(valid), 64'd0);
        chk({tag, "_sat"}, 64'(width_sat), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_count"}, 64'(pulse_count), 64'd0);
    endtask

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        din    = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        resetn = 1'b1;
        en     = 1'b1;
        hold(1'b0, 4);

        // 10/100 train: first rise only starts, valid one period + 3 edges later
        clr();
        r0 = cyc;
        repeat (5) pulse(10, 100);
        chk("p1_nvalid", 64'(q_w.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk_entry("p1", i, 10, 100, 1'b0);
        chk("p1_latency", 64'(cyc_at(0) - r0), 64'd103);
        chk("p1_count", 64'(pulse_count), 64'd4);

        // switch to 25/50 without a gap: first result still belongs to the old train
        clr();
        repeat (4) pulse(25, 50);
        chk("p2_nvalid", 64'(q_w.size()), 64'd4);
        chk_entry("p2_mixed", 0, 10, 100, 1'b0);
        for (int i = 1; i < 4; i++) chk_entry("p2", i, 25, 50, 1'b0);
        chk("p2_count", 64'(pulse_count), 64'd8);

        // 300-cycle high time saturates the 8-bit width
        clr();
        repeat (2) pulse(300, 1000);
        chk("p3_nvalid", 64'(q_w.size()), 64'd2);
        chk_entry("p3_prev", 0, 25, 50, 1'b0);
        chk_entry("p3_sat", 1, 255, 1000, 1'b1);
        chk("p3_count", 64'(pulse_count), 64'd10);

        // minimum pulses, then din stuck low long enough to time out
        clr();
        chk("p4_no_timeout_yet", 64'(to_cnt), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) r0 = cyc;
            pulse(1, 2);
        end
        hold(1'b0, 70000);
        chk("p4_nvalid", 64'(q_w.size()), 64'd4);
        chk_entry("p4_prev", 0, 255, 1000, 1'b1);
        for (int i = 1; i < 4; i++) chk_entry("p4_min", i, 1, 2, 1'b0);
        chk("p4_count", 64'(pulse_count), 64'd14);
        chk("p4_timeouts", 64'(to_cnt), 64'd1);
        chk("p4_timeout_cyc", 64'(to_cyc - r0), 64'd65538);

        // resume after timeout
        clr();
        r0 = cyc;
        repeat (2) pulse(10, 100);
        chk("p5_nvalid", 64'(q_w.size()), 64'd1);
        chk_entry("p5", 0, 10, 100, 1'b0);
        chk("p5_latency", 64'(cyc_at(0) - r0), 64'd103);
        chk("p5_count", 64'(pulse_count), 64'd15);

        // reset asserted mid-pulse clears outputs at once
        hold(1'b1, 5);
        resetn = 1'b0;
        #1;
        chk_zero("midrst");
        din = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        hold(1'b0, 5);
        clr();
        r0 = cyc;
        repeat (2) pulse(10, 100);
        chk("p6_nvalid", 64'(q_w.size()), 64'd1);
        chk_entry("p6", 0, 10, 100, 1'b0);
        chk("p6_latency", 64'(cyc_at(0) - r0), 64'd103);
        chk("p6_count", 64'(pulse_count), 64'd1);

        // en dropped for 5 cycles mid-LOW discards the pulse in progress
        clr();
        hold(1'b1, 10);
        hold(1'b0, 40);
        en = 1'b0;
        hold(1'b0, 5);
        chk("p7_frozen_count", 64'(pulse_count), 64'd2);
        chk("p7_frozen_nvalid", 64'(q_w.size()), 64'd1);
        en = 1'b1;
        hold(1'b0, 45);
        r0 = cyc;
        repeat (2) pulse(10, 100);
        chk("p7_nvalid", 64'(q_w.size()), 64'd2);
        chk_entry("p7", 1, 10, 100, 1'b0);
        chk("p7_latency", 64'(cyc_at(1) - r0), 64'd103);
        chk("p7_count", 64'(pulse_count), 64'd3);

        // en low exactly in the cycle a completing rise is seen
        hold(1'b1, 2);
        en = 1'b0;
        hold(1'b1, 1);
        en = 1'b1;
        hold(1'b1, 7);
        hold(1'b0, 90);
        chk("p8_nvalid_block", 64'(q_w.size()), 64'd2);
        chk("p8_count_block", 64'(pulse_count), 64'd3);
        r0 = cyc;
        repeat (2) pulse(10, 100);
        chk("p8_nvalid", 64'(q_w.size()), 64'd3);
        chk_entry("p8", 2, 10, 100, 1'b0);
        chk("p8_latency", 64'(cyc_at(2) - r0), 64'd103);
        chk("p8_count", 64'(pulse_count), 64'd4);

        chk("strobe_shape", 64'(strobe_err), 64'd0);
        chk("total_timeouts", 64'(to_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
